// File: rtl/rvx_reset_halt_controller_if.sv
// Button/core-control bundle between a board top and the reset/halt sequencer.
// The master side owns the raw push-buttons; the slave side (the sequencer)
// drives the core-facing reset, halt and running indications.
interface rvx_reset_halt_controller_if;
   logic reset_button;   // raw, active-high, asynchronous to clock
   logic halt_button;    // raw, active-high, asynchronous to clock
   logic core_reset_n;   // active-low reset to the rvx core
   logic core_halt;      // halt request to the rvx core
   logic running;        // high while the reset sequencer is in RUN

   modport master (
      output reset_button,
      output halt_button,
      input  core_reset_n,
      input  core_halt,
      input  running
   );

   modport slave (
      input  reset_button,
      input  halt_button,
      output core_reset_n,
      output core_halt,
      output running
   );
endinterface

// File: rtl/rvx_reset_halt_controller.sv
// Board-level reset/halt sequencer placed directly in front of the rvx core.
// Each raw button is brought into the clock domain by a 2-FF synchroniser and
// then debounced by a stable-value register plus a consecutive-sample counter.
// The debounced reset button drives an ASSERT/HOLD/RUN sequencer that
// guarantees a minimum core reset pulse; the debounced halt button drives
// core_halt either as a level or as a press-to-toggle control.
module rvx_reset_halt_controller #(
   parameter int unsigned DEBOUNCE_CYCLES   = 120000,
   parameter int unsigned RESET_HOLD_CYCLES = 16,
   parameter bit          HALT_TOGGLE       = 1'b0
) (
   input  logic                             clock,
   input  logic                             reset_n,
   rvx_reset_halt_controller_if.slave       bus
);

   // Debounce counter must reach DEBOUNCE_CYCLES-1; hold counter must reach
   // RESET_HOLD_CYCLES-1 (a 1-bit counter is kept for the degenerate hold of 1).
   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

   // Bit positions of the two buttons in the per-button vectors.
   localparam int BTN_RST = 0;
   localparam int BTN_HLT = 1;

   typedef enum logic [1:0] {
      ST_ASSERT = 2'd0,
      ST_HOLD   = 2'd1,
      ST_RUN    = 2'd2
   } state_e;

   logic [1:0]            btn_s;
   logic [1:0]            sync1_q;
   logic [1:0]            sync2_q;
   logic [1:0]            stable_q;
   logic [1:0]            stable_d;
   logic [1:0][DB_W-1:0]  db_cnt_q;
   logic [1:0][DB_W-1:0]  db_cnt_d;

   state_e                state_q;
   logic [HOLD_W-1:0]     hold_cnt_q;
   logic                  core_reset_n_q;
   logic                  running_q;

   logic                  rst_db_s;
   logic                  hlt_db_s;
   logic                  hlt_prev_q;
   logic                  hlt_rise_s;
   logic                  enter_assert_s;
   logic                  core_halt_q;
   logic                  core_halt_d;

   assign btn_s = {bus.halt_button, bus.reset_button};

   // Two-stage synchroniser for both raw buttons; only sync2_q is consumed.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 2'b00;
         sync2_q <= 2'b00;
      end else begin
         sync1_q <= btn_s;
         sync2_q <= sync1_q;
      end
   end

   // Debounce next state: accept a change only after DEBOUNCE_CYCLES
   // consecutive differing samples; any agreeing sample restarts the count.
   always_comb begin
      stable_d = stable_q;
      db_cnt_d = db_cnt_q;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] == stable_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DB_LAST) begin
            stable_d[i] = sync2_q[i];
            db_cnt_d[i] = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stable_q <= 2'b00;
         db_cnt_q <= '0;
      end else begin
         stable_q <= stable_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   assign rst_db_s = stable_q[BTN_RST];
   assign hlt_db_s = stable_q[BTN_HLT];

   // Reset sequencer: ASSERT while the button is held, then a full uninterrupted
   // HOLD before RUN; core_reset_n and running are dedicated flops updated on
   // the transitions into and out of RUN.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_ASSERT;
         hold_cnt_q     <= '0;
         core_reset_n_q <= 1'b0;
         running_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               if (!rst_db_s) begin
                  state_q    <= ST_HOLD;
                  hold_cnt_q <= '0;
               end else begin
                  state_q    <= ST_ASSERT;
               end
            end
            ST_HOLD: begin
               if (rst_db_s) begin
                  // A new press aborts the hold; the pulse restarts from scratch.
                  state_q <= ST_ASSERT;
               end else if (hold_cnt_q == HOLD_LAST) begin
                  state_q        <= ST_RUN;
                  core_reset_n_q <= 1'b1;
                  running_q      <= 1'b1;
               end else begin
                  hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
               end
            end
            ST_RUN: begin
               if (rst_db_s) begin
                  state_q        <= ST_ASSERT;
                  core_reset_n_q <= 1'b0;
                  running_q      <= 1'b0;
               end else begin
                  state_q <= ST_RUN;
               end
            end
            default: begin
               state_q        <= ST_ASSERT;
               hold_cnt_q     <= '0;
               core_reset_n_q <= 1'b0;
               running_q      <= 1'b0;
            end
         endcase
      end
   end

   // The sequencer moves to ASSERT exactly when the debounced reset is high
   // while it is in HOLD or RUN.
   assign enter_assert_s = rst_db_s && (state_q != ST_ASSERT);
   assign hlt_rise_s     = hlt_db_s && !hlt_prev_q;

   // Halt next state: level follow, or toggle on a debounced press while
   // running, with the clear on entering ASSERT taking priority.
   always_comb begin
      core_halt_d = core_halt_q;
      if (HALT_TOGGLE) begin
         if (enter_assert_s) begin
            core_halt_d = 1'b0;
         end else if (hlt_rise_s && (state_q == ST_RUN)) begin
            core_halt_d = ~core_halt_q;
         end else begin
            core_halt_d = core_halt_q;
         end
      end else begin
         core_halt_d = hlt_db_s;
      end
   end

   // Halt output flop and previous debounced halt value for edge detection.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         core_halt_q <= 1'b0;
         hlt_prev_q  <= 1'b0;
      end else begin
         core_halt_q <= core_halt_d;
         hlt_prev_q  <= hlt_db_s;
      end
   end

   assign bus.core_reset_n = core_reset_n_q;
   assign bus.running      = running_q;
   assign bus.core_halt    = core_halt_q;

endmodule

// File: tb/tb_rvx_reset_halt_controller.sv
// Directed bench for rvx_reset_halt_controller.
// u0: DEBOUNCE=4, HOLD=3, level halt.  u1: same timing, toggle halt.
// u2: DEBOUNCE=1, HOLD=3 -- with a 4-cycle debounce a re-press cannot get
// through the debouncer before a 3-cycle hold completes, so the
// abort-during-HOLD scenario is exercised on this faster-debounce copy.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_rvx_reset_halt_controller;

   logic clock;
   logic reset_n;
   int   n_cmp;
   int   n_bad;

   rvx_reset_halt_controller_if if0 ();
   rvx_reset_halt_controller_if if1 ();
   rvx_reset_halt_controller_if if2 ();

   rvx_reset_halt_controller #(
      .DEBOUNCE_CYCLES   (4),
      .RESET_HOLD_CYCLES (3),
      .HALT_TOGGLE       (1'b0)
   ) u0 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (if0)
   );

   rvx_reset_halt_controller #(
      .DEBOUNCE_CYCLES   (4),
      .RESET_HOLD_CYCLES (3),
      .HALT_TOGGLE       (1'b1)
   ) u1 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (if1)
   );

   rvx_reset_halt_controller #(
      .DEBOUNCE_CYCLES   (1),
      .RESET_HOLD_CYCLES (3),
      .HALT_TOGGLE       (1'b0)
   ) u2 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (if2)
   );

   // Free-running clock, period 10.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) begin
         tick();
      end
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Linear directed sequence.
   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset_n = 1'b0;
      if0.reset_button = 1'b0; if0.halt_button = 1'b0;
      if1.reset_button = 1'b0; if1.halt_button = 1'b0;
      if2.reset_button = 1'b0; if2.halt_button = 1'b0;
      ticks(3);

      // Reset state
      check("rst_u0_core_reset_n", if0.core_reset_n, 1'b0);
      check("rst_u0_core_halt",    if0.core_halt,    1'b0);
      check("rst_u0_running",      if0.running,      1'b0);
      check("rst_u1_core_reset_n", if1.core_reset_n, 1'b0);
      check("rst_u1_core_halt",    if1.core_halt,    1'b0);
      check("rst_u2_running",      if2.running,      1'b0);

      // 1: release reset_n -> core_reset_n high on the 4th edge
      reset_n = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check("t1_still_in_reset", if0.core_reset_n, 1'b0);
         check("t1_halt_low",       if0.core_halt,    1'b0);
      end
      tick();
      check("t1_core_reset_n_up", if0.core_reset_n, 1'b1);
      check("t1_running_up",      if0.running,      1'b1);
      check("t1_halt_low_run",    if0.core_halt,    1'b0);
      check("t1_u1_up",           if1.core_reset_n, 1'b1);
      check("t1_u2_up",           if2.core_reset_n, 1'b1);

      // 2: 3-cycle reset glitch is rejected
      if0.reset_button = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check("t2_glitch_high", if0.core_reset_n, 1'b1);
      end
      if0.reset_button = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         check("t2_glitch_after", if0.core_reset_n, 1'b1);
      end

      // 3: 20-cycle reset press
      if0.reset_button = 1'b1;
      ticks(6);
      check("t3_before_assert", if0.core_reset_n, 1'b1);
      tick();
      check("t3_asserted",      if0.core_reset_n, 1'b0);
      check("t3_running_low",   if0.running,      1'b0);
      for (int i = 8; i <= 20; i++) begin
         tick();
         check("t3_held", if0.core_reset_n, 1'b0);
      end
      if0.reset_button = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         tick();
         check("t3_release_low", if0.core_reset_n, 1'b0);
      end
      tick();
      check("t3_release_up",  if0.core_reset_n, 1'b1);
      check("t3_running_up",  if0.running,      1'b1);

      // Level halt: follows the debounced button with 7-edge latency each way
      if0.halt_button = 1'b1;
      ticks(6);
      check("lvl_halt_pre",  if0.core_halt, 1'b0);
      tick();
      check("lvl_halt_set",  if0.core_halt, 1'b1);
      ticks(3);
      if0.halt_button = 1'b0;
      ticks(6);
      check("lvl_halt_hold", if0.core_halt, 1'b1);
      tick();
      check("lvl_halt_clr",  if0.core_halt, 1'b0);

      // 4: re-press during HOLD restarts from ASSERT (u2, 1-cycle debounce)
      if2.reset_button = 1'b1;
      ticks(3);
      check("t4_pre_assert", if2.core_reset_n, 1'b1);
      tick();
      check("t4_asserted",   if2.core_reset_n, 1'b0);
      ticks(2);
      if2.reset_button = 1'b0;
      tick();
      if2.reset_button = 1'b1;
      check("t4_window", if2.core_reset_n, 1'b0);
      for (int i = 2; i <= 5; i++) begin
         tick();
         check("t4_window", if2.core_reset_n, 1'b0);
      end
      if2.reset_button = 1'b0;
      for (int i = 6; i <= 11; i++) begin
         tick();
         check("t4_full_hold", if2.core_reset_n, 1'b0);
      end
      tick();
      check("t4_run", if2.core_reset_n, 1'b1);

      // 5: toggle-mode halt on u1
      if1.halt_button = 1'b1;
      ticks(6);
      check("t5_pre_toggle1", if1.core_halt, 1'b0);
      tick();
      check("t5_toggle1",     if1.core_halt, 1'b1);
      ticks(3);
      if1.halt_button = 1'b0;
      ticks(10);
      check("t5_keep1",       if1.core_halt, 1'b1);
      if1.halt_button = 1'b1;
      ticks(6);
      check("t5_pre_toggle2", if1.core_halt, 1'b1);
      tick();
      check("t5_toggle2",     if1.core_halt, 1'b0);
      ticks(3);
      if1.halt_button = 1'b0;
      ticks(10);
      check("t5_keep0",       if1.core_halt, 1'b0);

      // 5b: halt press while held in ASSERT is ignored
      if1.reset_button = 1'b1;
      ticks(7);
      check("t5_u1_asserted", if1.core_reset_n, 1'b0);
      if1.halt_button = 1'b1;
      ticks(10);
      check("t5_assert_ignore", if1.core_halt, 1'b0);
      if1.halt_button = 1'b0;
      ticks(10);
      if1.reset_button = 1'b0;
      ticks(9);
      check("t5_u1_hold_low", if1.core_reset_n, 1'b0);
      tick();
      check("t5_u1_run",        if1.core_reset_n, 1'b1);
      check("t5_halt_after_run", if1.core_halt,   1'b0);

      // 5c: reset press clears a set halt on entry to ASSERT
      if1.halt_button = 1'b1;
      ticks(7);
      check("t5_halt_set_again", if1.core_halt, 1'b1);
      if1.halt_button = 1'b0;
      ticks(10);
      check("t5_halt_kept", if1.core_halt, 1'b1);
      if1.reset_button = 1'b1;
      ticks(6);
      check("t5_halt_before_clr", if1.core_halt,    1'b1);
      tick();
      check("t5_halt_cleared",    if1.core_halt,    1'b0);
      check("t5_reset_asserted",  if1.core_reset_n, 1'b0);
      if1.reset_button = 1'b0;
      ticks(10);
      check("t5_rerun",           if1.core_reset_n, 1'b1);
      check("t5_halt_still_clr",  if1.core_halt,    1'b0);

      // 6: reset_n asserted mid-debounce clears everything at once
      if0.halt_button = 1'b1;
      ticks(4);
      reset_n = 1'b0;
      #1;
      check("t6_async_rst_n",   if0.core_reset_n, 1'b0);
      check("t6_async_running", if0.running,      1'b0);
      check("t6_async_halt",    if0.core_halt,    1'b0);
      check("t6_async_u1",      if1.core_reset_n, 1'b0);
      ticks(2);
      reset_n = 1'b1;
      ticks(3);
      check("t6_rel_low",  if0.core_reset_n, 1'b0);
      tick();
      check("t6_rel_up",   if0.core_reset_n, 1'b1);
      ticks(2);
      check("t6_halt_fresh_count", if0.core_halt, 1'b0);
      tick();
      check("t6_halt_set",         if0.core_halt, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
